mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 21 ++
 rtl/mem_access.sv | 126 ++++++++++++
 tb/tb_mem_access.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Control-word bit positions and FSM state encoding shared by the memory stage.
package mem_access_pkg;

  localparam int REG_WRITE = 20;
  localparam int MEM_READ  = 21;
  localparam int MEM_WRITE = 22;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Errored entries must never write back, so the reg_write bit is dropped.
  function automatic logic [31:0] clr_reg_write(input logic [31:0] cw);
    logic [31:0] r;
    r = cw;
    r[REG_WRITE] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_access.sv
// Memory stage: passes ALU results through, or runs one bus load/store per entry with a timeout.
// Latency: 1 cycle for ALU ops and misaligned accesses; 2+ cycles for bus accesses (ack-driven).
// Backpressure: stall holds upstream while a bus access is pending; no downstream backpressure.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] b_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] c_m_w_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [31:0] d2_out,
  output logic [4:0]  rd_out,
  output logic [31:0] c_m_w_out,
  output logic        valid_out,
  output logic        err_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [4:0]    lat_rd;
  logic [31:0]   lat_cmw;

  logic is_mem;
  logic aligned;
  logic timeout_fire;

  assign is_mem       = c_m_w_in[MEM_READ] | c_m_w_in[MEM_WRITE];
  assign aligned      = (alu_in[1:0] == 2'b00);
  // Firing on TIMEOUT-1 keeps mem_req high for exactly TIMEOUT cycles.
  assign timeout_fire = (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = valid_in & is_mem & aligned;
      BUSY:    stall = ~(mem_ack | timeout_fire);
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_rd    <= '0;
      lat_cmw   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d2_out    <= '0;
      rd_out    <= '0;
      c_m_w_out <= '0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_out <= 1'b0;
          if (valid_in) begin
            if (!is_mem) begin
              d2_out    <= alu_in;
              rd_out    <= rd_in;
              c_m_w_out <= c_m_w_in;
              valid_out <= 1'b1;
              err_out   <= 1'b0;
            end else if (!aligned) begin
              d2_out    <= alu_in;
              rd_out    <= rd_in;
              c_m_w_out <= clr_reg_write(c_m_w_in);
              valid_out <= 1'b1;
              err_out   <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= c_m_w_in[MEM_WRITE];
              mem_addr  <= alu_in;
              mem_wdata <= b_in;
              lat_rd    <= rd_in;
              lat_cmw   <= c_m_w_in;
              wait_cnt  <= '0;
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          valid_out <= 1'b0;
          if (mem_ack) begin
            d2_out    <= mem_we ? mem_addr : mem_rdata;
            rd_out    <= lat_rd;
            c_m_w_out <= lat_cmw;
            valid_out <= 1'b1;
            err_out   <= 1'b0;
            mem_req   <= 1'b0;
            state     <= IDLE;
          end else if (timeout_fire) begin
            d2_out    <= '0;
            rd_out    <= lat_rd;
            c_m_w_out <= clr_reg_write(lat_cmw);
            valid_out <= 1'b1;
            err_out   <= 1'b1;
            mem_req   <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, load, store, timeout, misalignment, reset abort.
module tb_mem_access;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_in;
  logic [31:0] b_in;
  logic [4:0]  rd_in;
  logic [31:0] c_m_w_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [31:0] d2_out;
  logic [4:0]  rd_out;
  logic [31:0] c_m_w_out;
  logic        valid_out;
  logic        err_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] RW = 32'h0010_0000;
  localparam logic [31:0] RD = 32'h0020_0000;
  localparam logic [31:0] WR = 32'h0040_0000;

  mem_access #(.TIMEOUT(15)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (valid_in),
    .alu_in    (alu_in),
    .b_in      (b_in),
    .rd_in     (rd_in),
    .c_m_w_in  (c_m_w_in),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .d2_out    (d2_out),
    .rd_out    (rd_out),
    .c_m_w_out (c_m_w_out),
    .valid_out (valid_out),
    .err_out   (err_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] cw);
    valid_in = 1'b1;
    alu_in   = a;
    b_in     = b;
    rd_in    = rd;
    c_m_w_in = cw;
  endtask

  initial begin
    int stall_cnt;
    int req_cnt;

    reset     = 1'b1;
    valid_in  = 1'b0;
    alu_in    = '0;
    b_in      = '0;
    rd_in     = '0;
    c_m_w_in  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    tick();
    tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_d2_out", d2_out, 32'd0);
    chk("rst_c_m_w_out", c_m_w_out, 32'd0);
    reset = 1'b0;
    tick();

    // ALU pass-through
    issue(32'h1234, 32'h0, 5'd5, RW);
    #1;
    chk("alu_stall", {31'd0, stall}, 32'd0);
    tick();
    valid_in = 1'b0;
    chk("alu_valid", {31'd0, valid_out}, 32'd1);
    chk("alu_d2", d2_out, 32'h1234);
    chk("alu_rd", {27'd0, rd_out}, 32'd5);
    chk("alu_err", {31'd0, err_out}, 32'd0);
    chk("alu_cmw", c_m_w_out, RW);
    tick();
    chk("idle_valid", {31'd0, valid_out}, 32'd0);
    chk("idle_d2_hold", d2_out, 32'h1234);

    // Load, ack three cycles after mem_req rises
    issue(32'h100, 32'h0, 5'd7, RD | RW);
    stall_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end
      #1;
      if (stall) stall_cnt++;
      if (c == 1) begin
        chk("ld_req", {31'd0, mem_req}, 32'd1);
        chk("ld_we", {31'd0, mem_we}, 32'd0);
        chk("ld_addr", mem_addr, 32'h100);
        chk("ld_busy_valid", {31'd0, valid_out}, 32'd0);
      end
      tick();
    end
    mem_ack  = 1'b0;
    valid_in = 1'b0;
    chk("ld_stall_cycles", stall_cnt, 32'd4);
    chk("ld_valid", {31'd0, valid_out}, 32'd1);
    chk("ld_d2", d2_out, 32'hDEADBEEF);
    chk("ld_rd", {27'd0, rd_out}, 32'd7);
    chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
    tick();

    // Store, ack one cycle after mem_req rises
    issue(32'h200, 32'hCAFE, 5'd3, WR | RW);
    tick();
    chk("st_req", {31'd0, mem_req}, 32'd1);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_wdata", mem_wdata, 32'hCAFE);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack  = 1'b0;
    valid_in = 1'b0;
    chk("st_valid", {31'd0, valid_out}, 32'd1);
    chk("st_err", {31'd0, err_out}, 32'd0);
    chk("st_d2", d2_out, 32'h200);
    chk("st_cmw", c_m_w_out, WR | RW);
    tick();

    // Both read and write set: write wins; ack immediately gives the 2-cycle minimum
    issue(32'h500, 32'h77, 5'd2, RD | WR);
    tick();
    chk("rw_we", {31'd0, mem_we}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    tick();
    mem_ack  = 1'b0;
    valid_in = 1'b0;
    chk("min_lat_valid", {31'd0, valid_out}, 32'd1);
    chk("rw_d2", d2_out, 32'h500);
    tick();

    // Timeout: no ack at all
    issue(32'h300, 32'h0, 5'd9, RD | RW);
    tick();
    req_cnt = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      req_cnt++;
      tick();
    end
    valid_in = 1'b0;
    chk("to_req_cycles", req_cnt, 32'd15);
    chk("to_valid", {31'd0, valid_out}, 32'd1);
    chk("to_err", {31'd0, err_out}, 32'd1);
    chk("to_d2", d2_out, 32'd0);
    chk("to_cmw", c_m_w_out, RD);
    chk("to_rd", {27'd0, rd_out}, 32'd9);
    tick();

    // Ack arriving in the timeout cycle wins
    issue(32'h340, 32'h0, 5'd11, RD | RW);
    tick();
    for (int i = 0; i < 14; i++) tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack  = 1'b0;
    valid_in = 1'b0;
    chk("tack_err", {31'd0, err_out}, 32'd0);
    chk("tack_d2", d2_out, 32'h0BAD_F00D);
    chk("tack_cmw", c_m_w_out, RD | RW);
    tick();

    // Misaligned load
    issue(32'h102, 32'h0, 5'd4, RD | RW);
    #1;
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    valid_in = 1'b0;
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    chk("mis_valid", {31'd0, valid_out}, 32'd1);
    chk("mis_err", {31'd0, err_out}, 32'd1);
    chk("mis_cmw", c_m_w_out, RD);
    chk("mis_d2", d2_out, 32'h102);
    tick();

    // Reset in the middle of a bus access, then a stray ack
    issue(32'h400, 32'h0, 5'd6, RD | RW);
    tick();
    chk("rb_req", {31'd0, mem_req}, 32'd1);
    tick();
    reset    = 1'b1;
    valid_in = 1'b0;
    tick();
    reset = 1'b0;
    chk("rb_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rb_valid", {31'd0, valid_out}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, valid_out}, 32'd0);
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_d2", d2_out, 32'd0);
    tick();
    chk("late_ack_valid2", {31'd0, valid_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
